otp_ctrl: RTL and testbench

- Sequencer and arbiter in front of the OTP interface block (rom_* request side).
- After reset, it autonomously burst-reads a trim window from OTP into shadow registers and validates a checksum.
- It then serves single-byte host read and program requests; every program is followed by an automatic read-back verify.
- Sits between the system register bank (host side) and the OTP interface; gated by the same run_ctrl tick.

---
 rtl/otp_pkg.sv | 24 ++
 rtl/otp_shadow_regs.sv | 51 +++++
 rtl/otp_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_otp_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/otp_pkg.sv
// otp_pkg: shared definitions for the OTP sequencer/arbiter.
//   - OTP address/data widths
//   - boot-window index width and default trim window placement
//   - controller state encoding
package otp_pkg;

   localparam int OTP_AW = 7;
   localparam int OTP_DW = 8;
   localparam int IDX_W  = 5;

   localparam logic [OTP_AW-1:0] LOAD_BASE_DEF = 7'h70;
   localparam int                LOAD_LEN_DEF  = 4;

   typedef enum logic [2:0] {
      S_BOOT = 3'd0,
      S_CHK  = 3'd1,
      S_IDLE = 3'd2,
      S_HRD  = 3'd3,
      S_HWR  = 3'd4,
      S_VFY  = 3'd5,
      S_ACK  = 3'd6
   } state_e;

endpackage

// File: rtl/otp_shadow_regs.sv
// otp_shadow_regs: trim shadow array plus running checksum accumulator.
//   clk, rst   : clock, asynchronous active-low reset
//   we         : write wdata into shadow byte idx
//   add_en     : with we, also add wdata into the running sum
//   idx        : shadow byte index
//   wdata      : byte to store
//   trim_data  : flattened shadow array, byte i at [8i+7:8i]
//   sum        : 8-bit running sum of the bytes written with add_en
module otp_shadow_regs
   import otp_pkg::*;
#(
   parameter int LOAD_LEN = LOAD_LEN_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic                     add_en,
   input  logic [IDX_W-1:0]         idx,
   input  logic [OTP_DW-1:0]        wdata,
   output logic [8*LOAD_LEN-1:0]    trim_data,
   output logic [OTP_DW-1:0]        sum
);

   logic [LOAD_LEN-1:0][OTP_DW-1:0] shadow_q, shadow_d;
   logic [OTP_DW-1:0]               sum_q, sum_d;

   always_comb begin
      shadow_d = shadow_q;
      sum_d    = sum_q;
      if (we) begin
         for (int i = 0; i < LOAD_LEN; i++) begin
            if (idx == IDX_W'(i)) shadow_d[i] = wdata;
         end
         if (add_en) sum_d = sum_q + wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_q <= '0;
         sum_q    <= '0;
      end else begin
         shadow_q <= shadow_d;
         sum_q    <= sum_d;
      end
   end

   assign trim_data = shadow_q;
   assign sum       = sum_q;

endmodule

// File: rtl/otp_ctrl.sv
// otp_ctrl: boot-load sequencer and host arbiter in front of the OTP interface.
//   After reset it burst-reads LOAD_LEN bytes from LOAD_BASE into shadow
//   registers and checks the last byte against the sum of the others. It then
//   serves single-byte host reads and programs; each program is followed by
//   a read-back verify at the same address.
//   clk, rst          : clock, asynchronous active-low reset
//   run_ctrl          : clock enable for all state and registered outputs
//   rom_rctrl/wctrl   : read / program request, held until rom_ready
//   rom_addrs/wdata   : access address and program data (stable under ctrl)
//   rom_rdata/ready   : read data and completion strobe from OTP interface
//   host_req/wr/addr/wdata, prog_en : host request, sampled in IDLE
//   host_ack/rdata/err: completion pulse, result data, reject/verify error
//   trim_data         : shadow bytes, byte i at [8i+7:8i]
//   load_done/err     : sticky boot-complete and checksum-fail flags
module otp_ctrl
   import otp_pkg::*;
#(
   parameter logic [OTP_AW-1:0] LOAD_BASE = LOAD_BASE_DEF,
   parameter int                LOAD_LEN  = LOAD_LEN_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run_ctrl,
   output logic                  rom_rctrl,
   output logic                  rom_wctrl,
   output logic [OTP_AW-1:0]     rom_addrs,
   output logic [OTP_DW-1:0]     rom_wdata,
   input  logic [OTP_DW-1:0]     rom_rdata,
   input  logic                  rom_ready,
   input  logic                  host_req,
   input  logic                  host_wr,
   input  logic [OTP_AW-1:0]     host_addr,
   input  logic [OTP_DW-1:0]     host_wdata,
   input  logic                  prog_en,
   output logic                  host_ack,
   output logic [OTP_DW-1:0]     host_rdata,
   output logic                  host_err,
   output logic [8*LOAD_LEN-1:0] trim_data,
   output logic                  load_done,
   output logic                  load_err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LOAD_LEN - 1);
   localparam logic [OTP_AW:0]  WIN_END  = (OTP_AW+1)'(LOAD_BASE) + (OTP_AW+1)'(LOAD_LEN);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                rom_rctrl_q, rom_rctrl_d;
   logic                rom_wctrl_q, rom_wctrl_d;
   logic [OTP_AW-1:0]   rom_addrs_q, rom_addrs_d;
   logic [OTP_DW-1:0]   rom_wdata_q, rom_wdata_d;
   // Result of the transaction in flight; copied to host_* only with the ack
   // so host_rdata/host_err stay unchanged between acks.
   logic [OTP_DW-1:0]   res_data_q, res_data_d;
   logic                res_err_q, res_err_d;
   logic                host_ack_q, host_ack_d;
   logic [OTP_DW-1:0]   host_rdata_q, host_rdata_d;
   logic                host_err_q, host_err_d;
   logic                load_done_q, load_done_d;
   logic                load_err_q, load_err_d;

   logic                sh_we, sh_add;
   logic [IDX_W-1:0]    sh_idx;
   logic [OTP_DW-1:0]   sum;
   logic [OTP_DW-1:0]   chk_byte;
   logic                in_win;
   logic [IDX_W-1:0]    win_idx;

   assign chk_byte = trim_data[8*(LOAD_LEN-1) +: 8];
   assign in_win   = (rom_addrs_q >= LOAD_BASE) && ({1'b0, rom_addrs_q} < WIN_END);
   assign win_idx  = IDX_W'(rom_addrs_q - LOAD_BASE);

   otp_shadow_regs #(.LOAD_LEN(LOAD_LEN)) u_shadow (
      .clk       (clk),
      .rst       (rst),
      .we        (sh_we),
      .add_en    (sh_add),
      .idx       (sh_idx),
      .wdata     (rom_rdata),
      .trim_data (trim_data),
      .sum       (sum)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      rom_rctrl_d  = rom_rctrl_q;
      rom_wctrl_d  = rom_wctrl_q;
      rom_addrs_d  = rom_addrs_q;
      rom_wdata_d  = rom_wdata_q;
      res_data_d   = res_data_q;
      res_err_d    = res_err_q;
      host_ack_d   = host_ack_q;
      host_rdata_d = host_rdata_q;
      host_err_d   = host_err_q;
      load_done_d  = load_done_q;
      load_err_d   = load_err_q;
      sh_we        = 1'b0;
      sh_add       = 1'b0;
      sh_idx       = idx_q;

      // rom_ready is only honoured on enabled edges, so a ready that stays
      // high across stalled cycles is consumed exactly once.
      if (run_ctrl) begin
         host_ack_d = 1'b0;
         unique case (state_q)
            S_BOOT: begin
               if (!rom_rctrl_q) begin
                  rom_rctrl_d = 1'b1;
                  rom_addrs_d = LOAD_BASE + OTP_AW'(idx_q);
               end else if (rom_ready) begin
                  sh_we  = 1'b1;
                  // The checksum byte itself is not part of the sum.
                  sh_add = (idx_q != LAST_IDX);
                  if (idx_q != LAST_IDX) begin
                     idx_d       = idx_q + IDX_W'(1);
                     rom_addrs_d = LOAD_BASE + OTP_AW'(idx_q + IDX_W'(1));
                  end else begin
                     rom_rctrl_d = 1'b0;
                     state_d     = S_CHK;
                  end
               end
            end
            S_CHK: begin
               load_err_d  = (sum != chk_byte);
               load_done_d = 1'b1;
               state_d     = S_IDLE;
            end
            S_IDLE: begin
               if (host_req) begin
                  rom_addrs_d = host_addr;
                  rom_wdata_d = host_wdata;
                  if (!host_wr) begin
                     rom_rctrl_d = 1'b1;
                     state_d     = S_HRD;
                  end else if (prog_en) begin
                     rom_wctrl_d = 1'b1;
                     state_d     = S_HWR;
                  end else begin
                     res_err_d = 1'b1;
                     state_d   = S_ACK;
                  end
               end
            end
            S_HRD: begin
               if (rom_ready) begin
                  rom_rctrl_d = 1'b0;
                  res_data_d  = rom_rdata;
                  res_err_d   = 1'b0;
                  state_d     = S_ACK;
               end
            end
            S_HWR: begin
               // Switch straight into the verify read at the same address.
               if (rom_ready) begin
                  rom_wctrl_d = 1'b0;
                  rom_rctrl_d = 1'b1;
                  state_d     = S_VFY;
               end
            end
            S_VFY: begin
               if (rom_ready) begin
                  rom_rctrl_d = 1'b0;
                  res_data_d  = rom_rdata;
                  res_err_d   = (rom_rdata != rom_wdata_q);
                  sh_we       = in_win;
                  sh_idx      = win_idx;
                  state_d     = S_ACK;
               end
            end
            S_ACK: begin
               host_ack_d   = 1'b1;
               host_rdata_d = res_data_q;
               host_err_d   = res_err_q;
               state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_BOOT;
         idx_q        <= '0;
         rom_rctrl_q  <= 1'b0;
         rom_wctrl_q  <= 1'b0;
         rom_addrs_q  <= '0;
         rom_wdata_q  <= '0;
         res_data_q   <= '0;
         res_err_q    <= 1'b0;
         host_ack_q   <= 1'b0;
         host_rdata_q <= '0;
         host_err_q   <= 1'b0;
         load_done_q  <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         rom_rctrl_q  <= rom_rctrl_d;
         rom_wctrl_q  <= rom_wctrl_d;
         rom_addrs_q  <= rom_addrs_d;
         rom_wdata_q  <= rom_wdata_d;
         res_data_q   <= res_data_d;
         res_err_q    <= res_err_d;
         host_ack_q   <= host_ack_d;
         host_rdata_q <= host_rdata_d;
         host_err_q   <= host_err_d;
         load_done_q  <= load_done_d;
         load_err_q   <= load_err_d;
      end
   end

   assign rom_rctrl  = rom_rctrl_q;
   assign rom_wctrl  = rom_wctrl_q;
   assign rom_addrs  = rom_addrs_q;
   assign rom_wdata  = rom_wdata_q;
   assign host_ack   = host_ack_q;
   assign host_rdata = host_rdata_q;
   assign host_err   = host_err_q;
   assign load_done  = load_done_q;
   assign load_err   = load_err_q;

endmodule

// File: tb/tb_otp_ctrl.sv
// tb_otp_ctrl: scoreboard bench for otp_ctrl with a behavioural OTP model.
module tb_otp_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        run_ctrl = 1'b1;
   logic        rom_rctrl, rom_wctrl;
   logic [6:0]  rom_addrs;
   logic [7:0]  rom_wdata;
   logic [7:0]  rom_rdata;
   logic        rom_ready;
   logic        host_req = 1'b0;
   logic        host_wr = 1'b0;
   logic [6:0]  host_addr = '0;
   logic [7:0]  host_wdata = '0;
   logic        prog_en = 1'b0;
   logic        host_ack;
   logic [7:0]  host_rdata;
   logic        host_err;
   logic [31:0] trim_data;
   logic        load_done, load_err;

   otp_ctrl #(.LOAD_BASE(7'h70), .LOAD_LEN(4)) dut (
      .clk(clk), .rst(rst), .run_ctrl(run_ctrl),
      .rom_rctrl(rom_rctrl), .rom_wctrl(rom_wctrl), .rom_addrs(rom_addrs),
      .rom_wdata(rom_wdata), .rom_rdata(rom_rdata), .rom_ready(rom_ready),
      .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
      .host_wdata(host_wdata), .prog_en(prog_en), .host_ack(host_ack),
      .host_rdata(host_rdata), .host_err(host_err), .trim_data(trim_data),
      .load_done(load_done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string msg);
      checks++;
      failures++;
      $display("FAIL %s %s", name, msg);
   endtask

   // ---------------- OTP interface model (one-tick latency) ----------------
   bit [7:0] init_mem [0:127];
   bit [7:0] prog_mem [0:127];
   bit       prog_vld [0:127];
   bit       force_en = 1'b0;
   bit [7:0] force_val = 8'h00;
   int       acc_q[$];            // access log: 256|addr for program, addr for read

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         rom_ready <= 1'b0;
         rom_rdata <= 8'h00;
      end else if (run_ctrl) begin
         if (rom_ready) rom_ready <= 1'b0;
         else if (rom_wctrl) begin
            rom_ready <= 1'b1;
            prog_mem[rom_addrs] <= rom_wdata;
            prog_vld[rom_addrs] <= 1'b1;
            acc_q.push_back(256 | int'(rom_addrs));
         end else if (rom_rctrl) begin
            rom_ready <= 1'b1;
            rom_rdata <= force_en ? force_val :
                         (prog_vld[rom_addrs] ? prog_mem[rom_addrs] : init_mem[rom_addrs]);
            acc_q.push_back(int'(rom_addrs));
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   typedef struct {
      bit       err;
      bit [7:0] data;
      bit       chk_data;
   } exp_t;
   exp_t exp_q[$];

   int rctrl_falls = 0;
   int wctrl_hi = 0;

   initial begin
      exp_t e;
      logic ack_prev;
      logic rctrl_prev;
      ack_prev = 1'b0;
      rctrl_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rom_wctrl) wctrl_hi++;
         if (rctrl_prev && !rom_rctrl) rctrl_falls++;
         rctrl_prev = rom_rctrl;
         if (host_ack && !ack_prev) begin
            chk("ack_after_boot", load_done, 1);
            if (exp_q.size() == 0) fail("unexpected_ack", "actual=ack required=no_ack");
            else begin
               e = exp_q.pop_front();
               chk("ack_err", host_err, e.err);
               if (e.chk_data) chk("ack_rdata", host_rdata, e.data);
            end
         end
         ack_prev = host_ack;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_load(input int bound);
      int n = 0;
      while (!load_done && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (!load_done) fail("boot_timeout", "actual=load_done_low required=load_done_high");
   endtask

   task automatic start_req(input bit wr, input bit [6:0] a, input bit [7:0] d, input bit pe);
      host_req = 1'b1;
      host_wr = wr;
      host_addr = a;
      host_wdata = d;
      prog_en = pe;
   endtask

   // Counts enabled edges until host_ack is seen, then drops host_req
   // within the ack cycle.
   task automatic wait_ack(input int bound, output int cyc);
      bit seen = 1'b0;
      cyc = 0;
      while (!seen && cyc < bound) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (host_ack) seen = 1'b1;
      end
      host_req = 1'b0;
      if (!seen) fail("ack_timeout", "actual=no_ack required=ack");
      @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
   endtask

   initial begin
      int s, f, w0, cyc;
      bit did_rst;
      init_mem[7'h70] = 8'h11;
      init_mem[7'h71] = 8'h22;
      init_mem[7'h72] = 8'h33;
      init_mem[7'h73] = 8'h67;
      init_mem[7'h05] = 8'h5C;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rctrl", rom_rctrl, 0);
      chk("rst_wctrl", rom_wctrl, 0);
      chk("rst_addrs", rom_addrs, 0);
      chk("rst_wdata", rom_wdata, 0);
      chk("rst_ack", host_ack, 0);
      chk("rst_rdata", host_rdata, 0);
      chk("rst_err", host_err, 0);
      chk("rst_trim", trim_data, 0);
      chk("rst_done", load_done, 0);
      chk("rst_lerr", load_err, 0);

      // boot with bad checksum (11+22+33=66, stored 67)
      rst = 1'b1;
      wait_load(100);
      chk("bad_trim", trim_data, 32'h67332211);
      chk("bad_load_err", load_err, 1);
      chk("bad_load_done", load_done, 1);

      // boot with good checksum, host read pending from the first boot cycle
      init_mem[7'h73] = 8'h66;
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      s = acc_q.size();
      f = rctrl_falls;
      exp_q.push_back('{err: 1'b0, data: 8'h5C, chk_data: 1'b1});
      start_req(1'b0, 7'h05, 8'h00, 1'b1);
      wait_load(100);
      chk("req_held_in_boot", exp_q.size(), 1);
      chk("boot_rd_cnt", acc_q.size() - s, 4);
      for (int i = 0; i < 4; i++) chk("boot_addr", acc_q[s+i], 32'h70 + i);
      chk("boot_single_burst", rctrl_falls - f, 1);
      chk("good_trim", trim_data, 32'h66332211);
      chk("good_load_err", load_err, 0);
      chk("good_load_done", load_done, 1);
      wait_ack(50, cyc);
      chk("host_rd_addr", acc_q[s+4], 32'h05);

      // program + verify inside window, matching read-back
      @(posedge clk); #1;
      s = acc_q.size();
      exp_q.push_back('{err: 1'b0, data: 8'hA5, chk_data: 1'b1});
      start_req(1'b1, 7'h71, 8'hA5, 1'b1);
      wait_ack(50, cyc);
      chk("pgm_acc_cnt", acc_q.size() - s, 2);
      chk("pgm_wr", acc_q[s], 32'h171);
      chk("pgm_vfy_rd", acc_q[s+1], 32'h71);
      chk("pgm_trim", trim_data, 32'h6633A511);

      // program + verify with corrupted read-back
      force_en = 1'b1;
      force_val = 8'hA4;
      @(posedge clk); #1;
      exp_q.push_back('{err: 1'b1, data: 8'hA4, chk_data: 1'b1});
      start_req(1'b1, 7'h71, 8'hA5, 1'b1);
      wait_ack(50, cyc);
      chk("vfy_bad_trim", trim_data, 32'h6633A411);
      force_en = 1'b0;

      // rejected program (prog_en=0)
      @(posedge clk); #1;
      s = acc_q.size();
      w0 = wctrl_hi;
      exp_q.push_back('{err: 1'b1, data: 8'h00, chk_data: 1'b0});
      start_req(1'b1, 7'h10, 8'h5A, 1'b0);
      wait_ack(50, cyc);
      chk("reject_latency", cyc, 2);
      chk("reject_no_wctrl", wctrl_hi - w0, 0);
      chk("reject_no_access", acc_q.size() - s, 0);

      // run_ctrl toggling with an async reset in the middle of the burst
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      s = acc_q.size();
      did_rst = 1'b0;
      for (int n = 0; n < 400 && !(did_rst && load_done); n++) begin
         @(posedge clk); #1 run_ctrl = ~run_ctrl;
         if (!did_rst && (acc_q.size() - s) >= 2) begin
            #2 rst = 1'b0;
            #1;
            chk("midrst_rctrl", rom_rctrl, 0);
            chk("midrst_addrs", rom_addrs, 0);
            chk("midrst_trim", trim_data, 0);
            chk("midrst_done", load_done, 0);
            @(posedge clk); #1;
            @(posedge clk); #1 rst = 1'b1;
            did_rst = 1'b1;
            s = acc_q.size();
         end
      end
      run_ctrl = 1'b1;
      @(negedge clk);
      chk("tog_load_done", load_done, 1);
      chk("tog_rd_cnt", acc_q.size() - s, 4);
      for (int i = 0; i < 4; i++) chk("tog_addr", acc_q[s+i], 32'h70 + i);
      // 0x71 now holds the programmed A5: 11+A5+33 = E9 vs 66
      chk("tog_trim", trim_data, 32'h6633A511);
      chk("tog_load_err", load_err, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

endmodule
